hls_perf_monitor: RTL and testbench

- Synthesizable, parametrised successor to the testbench-only module/loop status monitors.
- Observes NUM_CH HLS block-level handshakes (ap_start/ap_ready/ap_done/ap_continue) plus per-channel loop iteration pulses.
- Accumulates per-channel statistics in hardware and exposes them through a registered read-out mux.
- Sits beside the SpMV top and its pipelined sub-kernels, so statistics survive into on-board runs rather than simulation CSV dumps only.

---
 rtl/hls_perf_pkg.sv | 43 ++++
 rtl/hls_perf_chan.sv | 160 ++++++++++++++++
 rtl/hls_perf_monitor.sv | 102 ++++++++++
 tb/tb_hls_perf_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_perf_pkg.sv
// Shared types, read-out field codes and the saturating adder used by the
// HLS handshake performance monitor.
package hls_perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // rd_sel field codes
    localparam logic [2:0] SEL_TXN   = 3'd0;
    localparam logic [2:0] SEL_BUSY  = 3'd1;
    localparam logic [2:0] SEL_MIN   = 3'd2;
    localparam logic [2:0] SEL_MAX   = 3'd3;
    localparam logic [2:0] SEL_ITER  = 3'd4;
    localparam logic [2:0] SEL_STALL = 3'd5;
    localparam logic [2:0] SEL_STATE = 3'd6;
    localparam logic [2:0] SEL_STAT  = 3'd7;

    // Bit positions inside the sticky overflow vector
    localparam int OVF_TXN   = 0;
    localparam int OVF_BUSY  = 1;
    localparam int OVF_ITER  = 2;
    localparam int OVF_STALL = 3;
    localparam int OVF_LAT   = 4;

    // Adds step to a width-bit value, clamping at all-ones.
    // Bit 64 of the result flags that the clamp was hit.
    function automatic logic [64:0] sat_add(input logic [63:0] value,
                                            input logic [1:0]  step,
                                            input int unsigned width);
        logic [63:0] lim;
        logic [64:0] sum;
        lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sum = {1'b0, value} + 65'(step);
        if (sum > {1'b0, lim})
            sat_add = {1'b1, lim};
        else
            sat_add = {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/hls_perf_chan.sv
// One monitored channel: handshake FSM, latency counter and the
// statistics registers that the top-level read mux exposes.
module hls_perf_chan
    import hls_perf_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int LAT_W = 24,
    parameter int ERR_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_ap_start,
    input  logic             i_ap_ready,
    input  logic             i_ap_done,
    input  logic             i_ap_continue,
    input  logic             i_iter_end,
    output state_t           o_state,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_txn,
    output logic [CNT_W-1:0] o_busy_cyc,
    output logic [CNT_W-1:0] o_iter,
    output logic [CNT_W-1:0] o_stall,
    output logic [LAT_W-1:0] o_min_lat,
    output logic [LAT_W-1:0] o_max_lat,
    output logic [ERR_W-1:0] o_err,
    output logic [4:0]       o_ovf
);

    state_t           r_state;
    logic [LAT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_txn, r_busy_cyc, r_iter, r_stall;
    logic [LAT_W-1:0] r_min, r_max;
    logic [ERR_W-1:0] r_err;
    logic [4:0]       r_ovf;

    logic             w_idle, w_in_busy, w_in_hold;
    logic             w_done, w_restart, w_active, w_stall_ev;
    logic [1:0]       w_busy_step, w_err_step;
    logic [64:0]      w_lat_s, w_txn_s, w_busy_s, w_iter_s, w_stall_s, w_err_s;
    logic [LAT_W-1:0] w_lat_fin;
    logic             w_unused;

    // Decode handshake events and precompute every saturated next value
    always_comb begin
        w_idle      = (r_state == IDLE);
        w_in_busy   = (r_state == BUSY);
        w_in_hold   = (r_state == HOLD);
        w_done      = w_in_busy & i_ap_done;
        w_restart   = w_done & i_ap_continue & i_ap_start;
        // The start-sampled cycle is the first cycle of a transaction; on a
        // back-to-back cycle it belongs to both the ending and the new one.
        w_active    = w_in_busy | (w_idle & i_ap_start);
        w_busy_step = {1'b0, w_active} + {1'b0, w_restart};
        w_stall_ev  = w_in_hold | (w_done & ~i_ap_continue);
        w_err_step  = {1'b0, w_idle & i_ap_done}
                    + {1'b0, w_idle & i_ap_ready & ~i_ap_start};
        w_lat_s     = sat_add(64'(r_lat), 2'd1, LAT_W);
        // Latency including the done cycle itself
        w_lat_fin   = w_lat_s[LAT_W-1:0];
        w_txn_s     = sat_add(64'(r_txn), {1'b0, w_done}, CNT_W);
        w_busy_s    = sat_add(64'(r_busy_cyc), w_busy_step, CNT_W);
        w_iter_s    = sat_add(64'(r_iter), {1'b0, i_iter_end}, CNT_W);
        w_stall_s   = sat_add(64'(r_stall), {1'b0, w_stall_ev}, CNT_W);
        w_err_s     = sat_add(64'(r_err), w_err_step, ERR_W);
    end

    assign w_unused = ^{w_lat_s[63:LAT_W], w_txn_s[63:CNT_W], w_busy_s[63:CNT_W],
                        w_iter_s[63:CNT_W], w_stall_s[63:CNT_W], w_err_s[64:ERR_W]};

    // Handshake FSM and latency counter; independent of enable and clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_lat   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_ap_start) begin
                        r_state <= BUSY;
                        r_lat   <= LAT_W'(1);
                    end
                end
                BUSY: begin
                    if (i_ap_done) begin
                        if (!i_ap_continue)
                            r_state <= HOLD;
                        else if (i_ap_start)
                            r_lat <= LAT_W'(1);
                        else
                            r_state <= IDLE;
                    end else begin
                        r_lat <= w_lat_fin;
                    end
                end
                HOLD: begin
                    if (i_ap_continue)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Statistics: clear wins over any same-cycle increment, enable freezes them
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_txn      <= '0;
            r_busy_cyc <= '0;
            r_iter     <= '0;
            r_stall    <= '0;
            r_min      <= '1;
            r_max      <= '0;
            r_err      <= '0;
            r_ovf      <= '0;
        end else if (i_clear) begin
            r_txn      <= '0;
            r_busy_cyc <= '0;
            r_iter     <= '0;
            r_stall    <= '0;
            r_min      <= '1;
            r_max      <= '0;
            r_err      <= '0;
            r_ovf      <= '0;
        end else begin
            if (w_in_busy && w_lat_s[64])
                r_ovf[OVF_LAT] <= 1'b1;
            if (i_enable) begin
                r_txn            <= w_txn_s[CNT_W-1:0];
                r_busy_cyc       <= w_busy_s[CNT_W-1:0];
                r_iter           <= w_iter_s[CNT_W-1:0];
                r_stall          <= w_stall_s[CNT_W-1:0];
                r_err            <= w_err_s[ERR_W-1:0];
                r_ovf[OVF_TXN]   <= r_ovf[OVF_TXN]   | w_txn_s[64];
                r_ovf[OVF_BUSY]  <= r_ovf[OVF_BUSY]  | w_busy_s[64];
                r_ovf[OVF_ITER]  <= r_ovf[OVF_ITER]  | w_iter_s[64];
                r_ovf[OVF_STALL] <= r_ovf[OVF_STALL] | w_stall_s[64];
                if (w_done) begin
                    if (w_lat_fin < r_min)
                        r_min <= w_lat_fin;
                    if (w_lat_fin > r_max)
                        r_max <= w_lat_fin;
                end
            end
        end
    end

    assign o_state    = r_state;
    assign o_busy     = (r_state == BUSY) || (r_state == HOLD);
    assign o_txn      = r_txn;
    assign o_busy_cyc = r_busy_cyc;
    assign o_iter     = r_iter;
    assign o_stall    = r_stall;
    assign o_min_lat  = r_min;
    assign o_max_lat  = r_max;
    assign o_err      = r_err;
    assign o_ovf      = r_ovf;

endmodule

// File: rtl/hls_perf_monitor.sv
// Multi-channel HLS block-level handshake monitor: one statistics channel per
// monitored block plus a registered read-out mux.
module hls_perf_monitor
    import hls_perf_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    parameter  int LAT_W  = 24,
    parameter  int SEL_W  = 3,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic [NUM_CH-1:0] iter_end,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy
);

    // Error counter occupies rd field 7 above the 8 flag bits
    localparam int ERR_W = (CNT_W > 8) ? CNT_W - 8 : 1;

    state_t           w_state    [NUM_CH];
    logic [CNT_W-1:0] w_txn      [NUM_CH];
    logic [CNT_W-1:0] w_busy_cyc [NUM_CH];
    logic [CNT_W-1:0] w_iter     [NUM_CH];
    logic [CNT_W-1:0] w_stall    [NUM_CH];
    logic [LAT_W-1:0] w_min      [NUM_CH];
    logic [LAT_W-1:0] w_max      [NUM_CH];
    logic [ERR_W-1:0] w_err      [NUM_CH];
    logic [4:0]       w_ovf      [NUM_CH];

    logic [63:0]      w_wide;
    logic [CNT_W-1:0] r_rd_data;
    logic             w_unused;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hls_perf_chan #(
            .CNT_W (CNT_W),
            .LAT_W (LAT_W),
            .ERR_W (ERR_W)
        ) u_chan (
            .i_clk         (clock),
            .i_rst         (reset),
            .i_enable      (enable),
            .i_clear       (clear),
            .i_ap_start    (ap_start[g]),
            .i_ap_ready    (ap_ready[g]),
            .i_ap_done     (ap_done[g]),
            .i_ap_continue (ap_continue[g]),
            .i_iter_end    (iter_end[g]),
            .o_state       (w_state[g]),
            .o_busy        (busy[g]),
            .o_txn         (w_txn[g]),
            .o_busy_cyc    (w_busy_cyc[g]),
            .o_iter        (w_iter[g]),
            .o_stall       (w_stall[g]),
            .o_min_lat     (w_min[g]),
            .o_max_lat     (w_max[g]),
            .o_err         (w_err[g]),
            .o_ovf         (w_ovf[g])
        );
    end

    // Select the requested field, zero-extended; out-of-range channels read 0
    always_comb begin
        w_wide = '0;
        if (32'(rd_ch) < NUM_CH) begin
            case (3'(rd_sel))
                SEL_TXN:   w_wide = 64'(w_txn[rd_ch]);
                SEL_BUSY:  w_wide = 64'(w_busy_cyc[rd_ch]);
                SEL_MIN:   w_wide = 64'(w_min[rd_ch]);
                SEL_MAX:   w_wide = 64'(w_max[rd_ch]);
                SEL_ITER:  w_wide = 64'(w_iter[rd_ch]);
                SEL_STALL: w_wide = 64'(w_stall[rd_ch]);
                SEL_STATE: w_wide = 64'(w_state[rd_ch]);
                SEL_STAT:  w_wide = (64'(w_err[rd_ch]) << 8) | 64'(w_ovf[rd_ch]);
                default:   w_wide = '0;
            endcase
        end
    end

    assign w_unused = ^w_wide[63:CNT_W];

    // Register the read data; it reflects statistics from before this edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_rd_data <= '0;
        else
            r_rd_data <= w_wide[CNT_W-1:0];
    end

    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_hls_perf_monitor.sv
// Self-checking bench for hls_perf_monitor: directed scenarios plus a random
// multi-channel phase scored against a transaction-level model.
module tb_hls_perf_monitor;

    localparam int NCH  = 3;
    localparam int CW   = 32;
    localparam int LW   = 24;
    localparam int SLEN = 400;

    logic           clock = 1'b0;
    logic           reset, enable, clear;
    logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_continue, iter_end;
    logic [1:0]     rd_ch;
    logic [2:0]     rd_sel;
    logic [CW-1:0]  rd_data;
    logic [NCH-1:0] busy;

    logic [0:0]     sm_lo, sm_hi, sm_iter, sm_rd_ch, sm_busy;
    logic [2:0]     sm_rd_sel;
    logic [3:0]     sm_rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [NCH-1:0] s_start [SLEN];
    logic [NCH-1:0] s_done  [SLEN];
    logic [NCH-1:0] s_cont  [SLEN];
    logic [NCH-1:0] s_iter  [SLEN];
    logic           s_clr   [SLEN];

    int e_n [NCH], e_busy [NCH], e_stall [NCH], e_min [NCH], e_max [NCH], e_iter [NCH];

    hls_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW), .LAT_W(LW), .SEL_W(3)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .iter_end(iter_end),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy)
    );

    hls_perf_monitor #(.NUM_CH(1), .CNT_W(4), .LAT_W(4), .SEL_W(3)) dut_small (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .ap_start(sm_lo), .ap_ready(sm_lo), .ap_done(sm_lo),
        .ap_continue(sm_hi), .iter_end(sm_iter),
        .rd_ch(sm_rd_ch), .rd_sel(sm_rd_sel), .rd_data(sm_rd_data), .busy(sm_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in;
        ap_start    = '0;
        ap_ready    = '0;
        ap_done     = '0;
        ap_continue = '1;
        iter_end    = '0;
        clear       = 1'b0;
    endtask

    task automatic sched_reset;
        for (int c = 0; c < SLEN; c++) begin
            s_start[c] = '0;
            s_done[c]  = '0;
            s_cont[c]  = '1;
            s_iter[c]  = '0;
            s_clr[c]   = 1'b0;
        end
    endtask

    // Transaction of latency L starting at cycle s; continue held low for h
    // cycles beginning with the done cycle.
    task automatic add_txn(input int ch, input int s, input int L, input int h);
        s_start[s][ch]     = 1'b1;
        s_done[s+L-1][ch]  = 1'b1;
        for (int k = 0; k < h; k++)
            s_cont[s+L-1+k][ch] = 1'b0;
    endtask

    task automatic play(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            ap_start    = s_start[c];
            ap_done     = s_done[c];
            ap_ready    = s_done[c];
            ap_continue = s_cont[c];
            iter_end    = s_iter[c];
            clear       = s_clr[c];
            tick();
        end
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int ch, input int sel, input logic [63:0] exp);
        rd_ch  = 2'(ch);
        rd_sel = 3'(sel);
        tick();
        chk(tag, 64'(rd_data), exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        idle_in();
        rd_ch = '0; rd_sel = '0;
        sm_lo = '0; sm_hi = '1; sm_iter = '0; sm_rd_ch = '0; sm_rd_sel = '0;
        tick(); tick();
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        rd_chk("reset_min", 0, 2, 64'hFF_FFFF);

        // Single transaction of latency 10
        sched_reset();
        add_txn(0, 0, 10, 0);
        play(0, 12);
        idle_in();
        rd_chk("t1_txn", 0, 0, 64'd1);
        rd_chk("t1_busy", 0, 1, 64'd10);
        rd_chk("t1_min", 0, 2, 64'd10);
        rd_chk("t1_max", 0, 3, 64'd10);
        rd_chk("t1_stall", 0, 5, 64'd0);
        rd_chk("t1_state", 0, 6, 64'd0);

        // Continue held low for four cycles from the done cycle
        pulse_clear();
        sched_reset();
        add_txn(0, 0, 3, 4);
        rd_ch = 2'd0; rd_sel = 3'd6;
        play(0, 3);
        chk("t2_state_hold", 64'(rd_data), 64'd2);
        chk("t2_busy_hold", 64'(busy[0]), 64'd1);
        play(4, 8);
        idle_in();
        rd_chk("t2_state_end", 0, 6, 64'd0);
        rd_chk("t2_stall", 0, 5, 64'd5);
        rd_chk("t2_txn", 0, 0, 64'd1);

        // Back-to-back latencies 3, 7, 5
        pulse_clear();
        sched_reset();
        add_txn(0, 0, 3, 0);
        add_txn(0, 2, 7, 0);
        add_txn(0, 8, 5, 0);
        play(0, 14);
        idle_in();
        rd_chk("t3_txn", 0, 0, 64'd3);
        rd_chk("t3_min", 0, 2, 64'd3);
        rd_chk("t3_max", 0, 3, 64'd7);
        rd_chk("t3_busy", 0, 1, 64'd15);

        // Disabled transaction, then clear inside a latency-6 transaction
        pulse_clear();
        sched_reset();
        add_txn(0, 0, 5, 0);
        enable = 1'b0;
        play(0, 6);
        enable = 1'b1;
        add_txn(0, 8, 6, 0);
        s_clr[9] = 1'b1;
        play(7, 16);
        idle_in();
        rd_chk("t4_txn", 0, 0, 64'd1);
        rd_chk("t4_min", 0, 2, 64'd6);
        rd_chk("t4_max", 0, 3, 64'd6);
        rd_chk("t4_busy", 0, 1, 64'd4);

        // Protocol errors on channel 1 and counter saturation on a 4-bit monitor
        pulse_clear();
        ap_done = 3'b010;
        tick();
        idle_in();
        rd_chk("t5_err_done", 1, 7, 64'h100);
        ap_ready = 3'b010;
        tick();
        idle_in();
        rd_chk("t5_err_ready", 1, 7, 64'h200);
        rd_chk("t5_txn_none", 1, 0, 64'd0);
        sm_iter = 1'b1;
        repeat (20) tick();
        sm_iter = 1'b0;
        sm_rd_sel = 3'd4;
        tick();
        chk("t5_iter_sat", 64'(sm_rd_data), 64'd15);
        sm_rd_sel = 3'd7;
        tick();
        chk("t5_iter_ovf", 64'(sm_rd_data), 64'd4);

        // Asynchronous reset between clock edges while busy
        ap_start = 3'b001;
        tick();
        ap_start = '0;
        repeat (3) tick();
        chk("t6_busy_before", 64'(busy), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_busy_async", 64'(busy), 64'd0);
        chk("t6_rd_async", 64'(rd_data), 64'd0);
        chk("t6_small_busy", 64'(sm_busy), 64'd0);
        tick();
        reset = 1'b0;
        rd_chk("t6_txn", 0, 0, 64'd0);
        rd_chk("t6_busy", 0, 1, 64'd0);
        rd_chk("t6_min", 0, 2, 64'hFF_FFFF);
        rd_chk("t6_max", 0, 3, 64'd0);
        rd_chk("t6_iter", 0, 4, 64'd0);
        rd_chk("t6_stall", 0, 5, 64'd0);
        rd_chk("t6_state", 0, 6, 64'd0);
        rd_chk("t6_stat", 0, 7, 64'd0);
        rd_chk("t6_oor_ch", NCH, 2, 64'd0);

        // Random multi-channel traffic against a transaction-level model
        pulse_clear();
        sched_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            int s;
            e_n[ch] = 0; e_busy[ch] = 0; e_stall[ch] = 0;
            e_min[ch] = 32'h00FF_FFFF; e_max[ch] = 0; e_iter[ch] = 0;
            s = $urandom_range(0, 3);
            while (s < SLEN - 20) begin
                int L, h;
                L = $urandom_range(2, 9);
                h = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                add_txn(ch, s, L, h);
                e_n[ch]++;
                e_busy[ch] += L;
                if (h > 0) e_stall[ch] += h + 1;
                if (L < e_min[ch]) e_min[ch] = L;
                if (L > e_max[ch]) e_max[ch] = L;
                if (h == 0 && $urandom_range(0, 2) == 0)
                    s = s + L - 1;
                else
                    s = s + L + h + $urandom_range(0, 3);
            end
            for (int c = 0; c < SLEN; c++) begin
                logic b;
                b = ($urandom_range(0, 3) == 0);
                s_iter[c][ch] = b;
                if (b) e_iter[ch]++;
            end
        end
        play(0, SLEN - 1);
        idle_in();
        tick();
        for (int ch = 0; ch < NCH; ch++) begin
            rd_chk($sformatf("rnd_txn_ch%0d", ch),   ch, 0, 64'(e_n[ch]));
            rd_chk($sformatf("rnd_busy_ch%0d", ch),  ch, 1, 64'(e_busy[ch]));
            rd_chk($sformatf("rnd_min_ch%0d", ch),   ch, 2, 64'(e_min[ch]));
            rd_chk($sformatf("rnd_max_ch%0d", ch),   ch, 3, 64'(e_max[ch]));
            rd_chk($sformatf("rnd_iter_ch%0d", ch),  ch, 4, 64'(e_iter[ch]));
            rd_chk($sformatf("rnd_stall_ch%0d", ch), ch, 5, 64'(e_stall[ch]));
            rd_chk($sformatf("rnd_stat_ch%0d", ch),  ch, 7, 64'd0);
        end
        chk("rnd_busy_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
